// File: rtl/kernel_cholesky_0_cdot_acc_if.sv
// Handshake and data bundle for the complex dot-product stage:
// start/len command, a/b term stream, and the rounded s result.
interface kernel_cholesky_0_cdot_acc_if #(
  parameter int DIN_W  = 14,
  parameter int LEN_W  = 8,
  parameter int DOUT_W = 16
) ();
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     start_rdy;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  a_re;
  logic signed [DIN_W-1:0]  a_im;
  logic signed [DIN_W-1:0]  b_re;
  logic signed [DIN_W-1:0]  b_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DOUT_W-1:0] s_re;
  logic signed [DOUT_W-1:0] s_im;
  logic                     ovf;

  modport master (
    output start, len, in_valid, a_re, a_im, b_re, b_im, out_ready,
    input  start_rdy, in_ready, out_valid, s_re, s_im, ovf
  );

  modport slave (
    input  start, len, in_valid, a_re, a_im, b_re, b_im, out_ready,
    output start_rdy, in_ready, out_valid, s_re, s_im, ovf
  );
endinterface

// File: rtl/kernel_cholesky_0_cdot_acc.sv
// Streaming complex dot product S = sum a[k]*conj(b[k]) with exact accumulation,
// round-half-up realignment and saturation to DOUT_W per component.
module kernel_cholesky_0_cdot_acc #(
  parameter int DIN_W   = 14,
  parameter int LEN_W   = 8,
  parameter int FRAC_SH = 13,
  parameter int DOUT_W  = 16
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  kernel_cholesky_0_cdot_acc_if.slave bus
);
  localparam int P_W   = 2*DIN_W + 1;
  localparam int ACC_W = P_W + LEN_W;
  localparam int T_W   = ACC_W + 1 - FRAC_SH;

  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W-FRAC_SH+1){1'b0}}, 1'b1, {(FRAC_SH-1){1'b0}}};
  localparam logic signed [T_W-1:0] MAXV = {{(T_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] MINV = {{(T_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                 state_reg, state_next;
  logic [LEN_W-1:0]       len_reg;
  logic [LEN_W-1:0]       cnt_reg;
  logic                   p1_valid_reg;
  logic [1:0][P_W-1:0]    p1_reg;
  logic [1:0][P_W-1:0]    p1_next;
  logic [1:0][DOUT_W-1:0] s_pk;
  logic [1:0]             ovf_pk;
  logic                   accept;
  logic                   start_go;
  logic                   result_load;

  logic signed [2*DIN_W-1:0] m_rr, m_ii, m_ir, m_ri;

  assign m_rr = bus.a_re * bus.b_re;
  assign m_ii = bus.a_im * bus.b_im;
  assign m_ir = bus.a_im * bus.b_re;
  assign m_ri = bus.a_re * bus.b_im;

  // Conjugating b flips the sign of b_im: re = ar*br + ai*bi, im = ai*br - ar*bi.
  assign p1_next[0] = {m_rr[2*DIN_W-1], m_rr} + {m_ii[2*DIN_W-1], m_ii};
  assign p1_next[1] = {m_ir[2*DIN_W-1], m_ir} - {m_ri[2*DIN_W-1], m_ri};

  assign accept      = bus.in_valid && (state_reg == RUN);
  assign start_go    = bus.start && (state_reg == IDLE);
  // The accumulator already holds every term once P1 has emptied.
  assign result_load = (state_reg == DRAIN) && !p1_valid_reg;

  always_comb begin
    state_next    = state_reg;
    bus.start_rdy = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.start_rdy = 1'b1;
        if (bus.start) state_next = (bus.len == '0) ? OUT : RUN;
      end
      RUN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (cnt_reg + 1'b1 == len_reg)) state_next = DRAIN;
      end
      DRAIN: begin
        if (!p1_valid_reg) state_next = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      cnt_reg      <= '0;
      p1_valid_reg <= 1'b0;
      p1_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      p1_valid_reg <= accept;
      if (start_go) begin
        len_reg <= bus.len;
        cnt_reg <= '0;
      end else if (accept) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (accept) p1_reg <= p1_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [ACC_W-1:0]  acc_reg;
      logic signed [ACC_W:0]    rnd;
      logic signed [T_W-1:0]    t_val;
      logic [DOUT_W-1:0]        sat_val;
      logic                     sat_hit;
      logic [DOUT_W-1:0]        s_reg;
      logic                     ovf_reg;

      assign rnd   = {acc_reg[ACC_W-1], acc_reg} + HALF;
      assign t_val = rnd[ACC_W:FRAC_SH];

      always_comb begin
        sat_val = t_val[DOUT_W-1:0];
        sat_hit = 1'b0;
        if (t_val > MAXV) begin
          sat_val = MAXV[DOUT_W-1:0];
          sat_hit = 1'b1;
        end else if (t_val < MINV) begin
          sat_val = MINV[DOUT_W-1:0];
          sat_hit = 1'b1;
        end
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          acc_reg <= '0;
          s_reg   <= '0;
          ovf_reg <= 1'b0;
        end else begin
          if (start_go) begin
            acc_reg <= '0;
          end else if (p1_valid_reg) begin
            acc_reg <= acc_reg + {{LEN_W{p1_reg[gi][P_W-1]}}, p1_reg[gi]};
          end
          // A zero-length job reports an exact zero without touching the accumulator path.
          if (start_go && (bus.len == '0)) begin
            s_reg   <= '0;
            ovf_reg <= 1'b0;
          end else if (result_load) begin
            s_reg   <= sat_val;
            ovf_reg <= sat_hit;
          end
        end
      end

      assign s_pk[gi]   = s_reg;
      assign ovf_pk[gi] = ovf_reg;
    end
  endgenerate

  assign bus.s_re = s_pk[0];
  assign bus.s_im = s_pk[1];
  assign bus.ovf  = |ovf_pk;
endmodule

// File: tb/tb_kernel_cholesky_0_cdot_acc.sv
// Directed bench for the complex dot-product stage: the driver pushes hand-computed
// results into a scoreboard, a monitor checks latency and values on each output.
module tb_kernel_cholesky_0_cdot_acc;
  localparam int DIN_W  = 14;
  localparam int LEN_W  = 8;
  localparam int DOUT_W = 16;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  kernel_cholesky_0_cdot_acc_if #(.DIN_W(DIN_W), .LEN_W(LEN_W), .DOUT_W(DOUT_W)) bus ();

  kernel_cholesky_0_cdot_acc #(.DIN_W(DIN_W), .LEN_W(LEN_W), .FRAC_SH(13), .DOUT_W(DOUT_W)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    int    re;
    int    im;
    int    ovf;
    int    exp_cyc;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_ov  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: latency on the first out_valid cycle, values on the handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got out_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          chk({sb[0].name, "_lat"}, cyc, sb[0].exp_cyc);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, "_re"}, int'(bus.s_re), e.re);
        chk({e.name, "_im"}, int'(bus.s_im), e.im);
        chk({e.name, "_ovf"}, int'(bus.ovf), e.ovf);
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic wait_start_rdy(input string name);
    int guard = 0;
    while (!bus.start_rdy && guard < 100) begin
      tick();
      guard++;
    end
    if (!bus.start_rdy) chk({name, "_start_rdy_timeout"}, 0, 1);
  endtask

  task automatic set_terms(input int ar, input int ai, input int br, input int bi);
    bus.a_re = DIN_W'(ar);
    bus.a_im = DIN_W'(ai);
    bus.b_re = DIN_W'(br);
    bus.b_im = DIN_W'(bi);
  endtask

  // Every term of a job carries the same a/b; gap=1 toggles in_valid 1,0,1,0...
  task automatic run_job(input string name, input int n, input int ar, input int ai,
                         input int br, input int bi, input bit gap,
                         input int ere, input int eim, input int eovf, input bit start_in_run);
    int acc_cnt = 0;
    int guard   = 0;
    bit ph      = 1'b1;
    exp_t e;
    wait_start_rdy(name);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    if (n == 0) begin
      e = '{ere, eim, eovf, cyc + 1, name};
      sb.push_back(e);
    end
    tick();
    bus.start = 1'b0;
    while (acc_cnt < n && guard < 300) begin
      set_terms(ar, ai, br, bi);
      bus.in_valid = gap ? ph : 1'b1;
      bus.start    = start_in_run;
      bus.len      = LEN_W'(1);
      ph = ~ph;
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        if (acc_cnt == n) begin
          e = '{ere, eim, eovf, cyc + 3, name};
          sb.push_back(e);
        end
      end
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (acc_cnt < n) chk({name, "_accept_timeout"}, acc_cnt, n);
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((sb.size() != 0 || !bus.start_rdy) && guard < 200) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) chk({name, "_drain_timeout"}, sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_start_rdy"}, int'(bus.start_rdy), 1);
    chk({name, "_in_ready"}, int'(bus.in_ready), 0);
    chk({name, "_out_valid"}, int'(bus.out_valid), 0);
    chk({name, "_s_re"}, int'(bus.s_re), 0);
    chk({name, "_s_im"}, int'(bus.s_im), 0);
    chk({name, "_ovf"}, int'(bus.ovf), 0);
  endtask

  initial begin
    int guard;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_terms(0, 0, 0, 0);

    repeat (3) tick();
    chk_reset_outputs("rst_hold");
    ap_rst_n = 1'b1;
    tick();
    chk_reset_outputs("rst_rel");

    // 8191*8191 = 67092481; (x + 4096) >>> 13 = 8190
    run_job("t1", 1, 8191, 0, 8191, 0, 1'b0, 8190, 0, 0, 1'b0);
    run_job("t2a", 1, 0, 4096, 4096, 0, 1'b0, 0, 2048, 0, 1'b0);
    run_job("t2b", 1, 4096, 0, 0, 4096, 1'b0, 0, -2048, 0, 1'b0);
    // re term = 2*4096^2 = 2^25, four terms 2^27, >>> 13 = 16384; im terms cancel
    run_job("t3", 4, 4096, 4096, 4096, 4096, 1'b0, 16384, 0, 0, 1'b0);
    run_job("t3gap", 4, 4096, 4096, 4096, 4096, 1'b1, 16384, 0, 0, 1'b0);
    // 8 * 2^27 = 2^30 -> 131072 clamps high
    run_job("t4pos", 8, -8192, -8192, -8192, -8192, 1'b0, 32767, 0, 1, 1'b0);
    // 8 * (-8192*8191) -> -65528 clamps low
    run_job("t4neg", 8, -8192, 0, 8191, 0, 1'b0, -32768, 0, 1, 1'b0);
    run_job("t5len0", 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    run_job("t5start", 4, 4096, 4096, 4096, 4096, 1'b1, 16384, 0, 0, 1'b1);
    wait_idle("t5start");

    // re: 4096*2048 - 2048*4096 = 0; im: -2048*2048 - 4096*4096 = -20971520 -> -2560
    bus.out_ready = 1'b0;
    run_job("t5hold", 1, 4096, -2048, 2048, 4096, 1'b0, 0, -2560, 0, 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_s_re", int'(bus.s_re), 0);
      chk("hold_s_im", int'(bus.s_im), -2560);
      chk("hold_start_rdy", int'(bus.start_rdy), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle("t5hold");

    // Abort a len=4 job during its second term; the held -2560 must clear too.
    wait_start_rdy("t6");
    bus.start = 1'b1;
    bus.len   = LEN_W'(4);
    tick();
    bus.start = 1'b0;
    set_terms(4096, 4096, 4096, 4096);
    bus.in_valid = 1'b1;
    tick();
    #2 ap_rst_n = 1'b0;
    #1 chk_reset_outputs("t6_rst");
    bus.in_valid = 1'b0;
    repeat (2) tick();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_out", int'(bus.out_valid), 0);
    end
    run_job("t6after", 1, -8192, 0, -8192, 0, 1'b0, 8192, 0, 0, 1'b0);
    wait_idle("t6after");

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
